// File: rtl/rf_wb_pkg.sv
// Shared defaults and entry type for the register-file writeback queue.
// Optional forwarding search is enabled with RF_WB_FWD_EN.
package rf_wb_pkg;

    localparam int RF_WB_DEPTH = 4;
    localparam int RF_WB_AW    = 5;
    localparam int RF_WB_DW    = 32;

    typedef struct packed {
        logic [RF_WB_AW-1:0] rd;
        logic [RF_WB_DW-1:0] data;
    } rf_wb_entry_t;

endpackage

// File: rtl/rf_wb_fifo.sv
// In-order queue with two push slots (push0 older) and one pop per cycle.
// Exposes every slot ordered by age (index 0 = head) for the forwarding search.
module rf_wb_fifo
    import rf_wb_pkg::*;
#(
    parameter int DEPTH = RF_WB_DEPTH,
    parameter int AW    = RF_WB_AW,
    parameter int DW    = RF_WB_DW,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push0,
    input  logic [AW-1:0] push0_rd,
    input  logic [DW-1:0] push0_data,
    input  logic          push1,
    input  logic [AW-1:0] push1_rd,
    input  logic [DW-1:0] push1_data,
    input  logic          pop,
    output logic [CW-1:0] count,
    output logic          age_vld  [DEPTH],
    output logic [AW-1:0] age_rd   [DEPTH],
    output logic [DW-1:0] age_data [DEPTH]
);

    logic [AW-1:0] mem_rd   [DEPTH];
    logic [DW-1:0] mem_data [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW-1:0] slot1;
    logic [1:0]    n_push;

    // A discarded push0 lets push1 take the tail slot directly.
    assign slot1  = tail + PW'(push0);
    assign n_push = {1'b0, push0} + {1'b0, push1};

    always_ff @(posedge clk) begin
        if (push0) begin
            mem_rd[tail]   <= push0_rd;
            mem_data[tail] <= push0_data;
        end
        if (push1) begin
            mem_rd[slot1]   <= push1_rd;
            mem_data[slot1] <= push1_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            tail  <= tail + PW'(n_push);
            head  <= head + PW'(pop);
            count <= count + CW'(n_push) - CW'(pop);
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            age_vld[i]  = CW'(i) < count;
            age_rd[i]   = mem_rd[head + PW'(i)];
            age_data[i] = mem_data[head + PW'(i)];
        end
    end

endmodule

// File: rtl/rf_writeback_queue.sv
// Register-file write requester: mem/alu handshakes, in-order queue, forwarding.
// Define RF_WB_FWD_EN to build the forwarding search; otherwise fwd outputs are 0.
module rf_writeback_queue
    import rf_wb_pkg::*;
#(
    parameter int DEPTH = RF_WB_DEPTH,
    parameter int AW    = RF_WB_AW,
    parameter int DW    = RF_WB_DW,
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          mem_valid,
    output logic          mem_ready,
    input  logic [AW-1:0] mem_rd,
    input  logic [DW-1:0] mem_data,
    input  logic          alu_valid,
    output logic          alu_ready,
    input  logic [AW-1:0] alu_rd,
    input  logic [DW-1:0] alu_data,
    input  logic          rf_stall,
    output logic          rf_write,
    output logic [AW-1:0] rf_write_reg,
    output logic [DW-1:0] rf_write_data,
    input  logic [AW-1:0] fwd_rs1,
    input  logic [AW-1:0] fwd_rs2,
    output logic          fwd_hit1,
    output logic          fwd_hit2,
    output logic [DW-1:0] fwd_data1,
    output logic [DW-1:0] fwd_data2,
    output logic [CW-1:0] q_count
);

    logic [CW-1:0] count;
    logic [CW-1:0] free;
    logic          mem_acc;
    logic          alu_acc;
    logic          push0;
    logic          push1;
    logic          pop;
    logic          age_vld  [DEPTH];
    logic [AW-1:0] age_rd   [DEPTH];
    logic [DW-1:0] age_data [DEPTH];

    // Readiness looks only at registered occupancy; a same-cycle pop frees nothing.
    assign free      = CW'(DEPTH) - count;
    assign mem_ready = free >= CW'(1);
    assign alu_ready = (free >= CW'(2)) || (free == CW'(1) && !mem_valid);
    assign mem_acc   = mem_valid && mem_ready;
    assign alu_acc   = alu_valid && alu_ready;
    assign push0     = mem_acc && (mem_rd != '0);
    assign push1     = alu_acc && (alu_rd != '0);
    assign pop       = (count != '0) && !rf_stall;
    assign q_count   = count;

    rf_wb_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push0      (push0),
        .push0_rd   (mem_rd),
        .push0_data (mem_data),
        .push1      (push1),
        .push1_rd   (alu_rd),
        .push1_data (alu_data),
        .pop        (pop),
        .count      (count),
        .age_vld    (age_vld),
        .age_rd     (age_rd),
        .age_data   (age_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_write      <= 1'b0;
            rf_write_reg  <= '0;
            rf_write_data <= '0;
        end else begin
            rf_write <= pop;
            if (pop) begin
                rf_write_reg  <= age_rd[0];
                rf_write_data <= age_data[0];
            end
        end
    end

`ifdef RF_WB_FWD_EN
    // Oldest first so younger matches override; output register is oldest of all.
    always_comb begin
        fwd_hit1  = 1'b0;
        fwd_hit2  = 1'b0;
        fwd_data1 = '0;
        fwd_data2 = '0;
        if (rf_write && rf_write_reg == fwd_rs1) begin
            fwd_hit1  = 1'b1;
            fwd_data1 = rf_write_data;
        end
        if (rf_write && rf_write_reg == fwd_rs2) begin
            fwd_hit2  = 1'b1;
            fwd_data2 = rf_write_data;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (age_vld[i] && age_rd[i] == fwd_rs1) begin
                fwd_hit1  = 1'b1;
                fwd_data1 = age_data[i];
            end
            if (age_vld[i] && age_rd[i] == fwd_rs2) begin
                fwd_hit2  = 1'b1;
                fwd_data2 = age_data[i];
            end
        end
        if (fwd_rs1 == '0) begin
            fwd_hit1  = 1'b0;
            fwd_data1 = '0;
        end
        if (fwd_rs2 == '0) begin
            fwd_hit2  = 1'b0;
            fwd_data2 = '0;
        end
    end
`else
    logic unused_fwd;

    assign fwd_hit1  = 1'b0;
    assign fwd_hit2  = 1'b0;
    assign fwd_data1 = '0;
    assign fwd_data2 = '0;

    always_comb begin
        unused_fwd = ^{fwd_rs1, fwd_rs2};
        for (int i = 0; i < DEPTH; i++) begin
            unused_fwd = unused_fwd ^ age_vld[i] ^ (^age_rd[i]);
            unused_fwd = unused_fwd ^ (^age_data[i]);
        end
    end
`endif

endmodule

// File: tb/tb_rf_writeback_queue.sv
// Directed bench for rf_writeback_queue; forwarding expectations follow
// RF_WB_FWD_EN so the same bench covers both builds.
module tb_rf_writeback_queue;

`ifdef RF_WB_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        mem_valid;
    logic        mem_ready;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        rf_stall;
    logic        rf_write;
    logic [4:0]  rf_write_reg;
    logic [31:0] rf_write_data;
    logic [4:0]  fwd_rs1;
    logic [4:0]  fwd_rs2;
    logic        fwd_hit1;
    logic        fwd_hit2;
    logic [31:0] fwd_data1;
    logic [31:0] fwd_data2;
    logic [2:0]  q_count;

    int errors = 0;
    int checks = 0;

    rf_writeback_queue dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .mem_valid     (mem_valid),
        .mem_ready     (mem_ready),
        .mem_rd        (mem_rd),
        .mem_data      (mem_data),
        .alu_valid     (alu_valid),
        .alu_ready     (alu_ready),
        .alu_rd        (alu_rd),
        .alu_data      (alu_data),
        .rf_stall      (rf_stall),
        .rf_write      (rf_write),
        .rf_write_reg  (rf_write_reg),
        .rf_write_data (rf_write_data),
        .fwd_rs1       (fwd_rs1),
        .fwd_rs2       (fwd_rs2),
        .fwd_hit1      (fwd_hit1),
        .fwd_hit2      (fwd_hit2),
        .fwd_data1     (fwd_data1),
        .fwd_data2     (fwd_data2),
        .q_count       (q_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input string tag, input logic w,
                      input logic [4:0] r, input logic [31:0] d,
                      input logic [2:0] c);
        chk({tag, ".write"}, 32'(rf_write), 32'(w));
        if (w) begin
            chk({tag, ".reg"}, 32'(rf_write_reg), 32'(r));
            chk({tag, ".data"}, rf_write_data, d);
        end
        chk({tag, ".count"}, 32'(q_count), 32'(c));
    endtask

    task automatic push(input logic mv, input logic [4:0] mr,
                        input logic [31:0] md, input logic av,
                        input logic [4:0] ar, input logic [31:0] ad);
        mem_valid = mv;
        mem_rd    = mr;
        mem_data  = md;
        alu_valid = av;
        alu_rd    = ar;
        alu_data  = ad;
    endtask

    initial begin
        rst_n    = 1'b0;
        rf_stall = 1'b0;
        fwd_rs1  = '0;
        fwd_rs2  = '0;
        push(0, 0, 0, 0, 0, 0);
        tick();
        tick();
        chk("rst.write", 32'(rf_write), 0);
        chk("rst.reg", 32'(rf_write_reg), 0);
        chk("rst.data", rf_write_data, 0);
        chk("rst.count", 32'(q_count), 0);
        chk("rst.mem_ready", 32'(mem_ready), 1);
        chk("rst.alu_ready", 32'(alu_ready), 1);
        chk("rst.hit1", 32'(fwd_hit1), 0);
        rst_n = 1'b1;
        tick();

        // single alu push
        push(0, 0, 0, 1, 5'd3, 32'hA5A5A5A5);
        #1;
        chk("t1.alu_ready", 32'(alu_ready), 1);
        tick();
        push(0, 0, 0, 0, 0, 0);
        fwd_rs1 = 5'd3;
        #1;
        wr("t1.acc", 0, 0, 0, 3'd1);
        chk("t1.q.hit", 32'(fwd_hit1), 32'(FWD));
        chk("t1.q.data", fwd_data1, FWD ? 32'hA5A5A5A5 : 32'h0);
        tick();
        wr("t1.pop", 1, 5'd3, 32'hA5A5A5A5, 3'd0);
        chk("t1.o.hit", 32'(fwd_hit1), 32'(FWD));
        chk("t1.o.data", fwd_data1, FWD ? 32'hA5A5A5A5 : 32'h0);
        tick();
        chk("t1.idle", 32'(rf_write), 0);
        chk("t1.hold", 32'(rf_write_reg), 3);
        chk("t1.miss", 32'(fwd_hit1), 0);

        // mem and alu same cycle, same rd
        push(1, 5'd5, 32'h11, 1, 5'd5, 32'h22);
        fwd_rs1 = 5'd5;
        fwd_rs2 = 5'd9;
        #1;
        chk("t2.mem_ready", 32'(mem_ready), 1);
        chk("t2.alu_ready", 32'(alu_ready), 1);
        tick();
        push(0, 0, 0, 0, 0, 0);
        #1;
        wr("t2.acc", 0, 0, 0, 3'd2);
        chk("t2.young", fwd_data1, FWD ? 32'h22 : 32'h0);
        chk("t2.miss.hit", 32'(fwd_hit2), 0);
        chk("t2.miss.data", fwd_data2, 0);
        tick();
        wr("t2.w0", 1, 5'd5, 32'h11, 3'd1);
        chk("t2.young2", fwd_data1, FWD ? 32'h22 : 32'h0);
        tick();
        wr("t2.w1", 1, 5'd5, 32'h22, 3'd0);
        tick();
        chk("t2.idle", 32'(rf_write), 0);

        // fill under stall, then drain
        rf_stall = 1'b1;
        push(1, 5'd1, 32'h101, 1, 5'd2, 32'h202);
        tick();
        chk("t3.c2", 32'(q_count), 2);
        push(1, 5'd3, 32'h303, 1, 5'd4, 32'h404);
        #1;
        chk("t3.alu_ready2", 32'(alu_ready), 1);
        tick();
        push(0, 0, 0, 0, 0, 0);
        #1;
        wr("t3.full", 0, 0, 0, 3'd4);
        chk("t3.mem_ready", 32'(mem_ready), 0);
        chk("t3.alu_ready", 32'(alu_ready), 0);
        rf_stall = 1'b0;
        tick();
        wr("t3.w1", 1, 5'd1, 32'h101, 3'd3);
        tick();
        wr("t3.w2", 1, 5'd2, 32'h202, 3'd2);
        tick();
        wr("t3.w3", 1, 5'd3, 32'h303, 3'd1);
        tick();
        wr("t3.w4", 1, 5'd4, 32'h404, 3'd0);
        tick();
        chk("t3.idle", 32'(rf_write), 0);
        chk("t3.mem_ready1", 32'(mem_ready), 1);
        chk("t3.alu_ready1", 32'(alu_ready), 1);

        // free == 1 with both channels valid
        rf_stall = 1'b1;
        push(1, 5'd6, 32'h606, 1, 5'd7, 32'h707);
        tick();
        push(1, 5'd8, 32'h808, 0, 0, 0);
        tick();
        chk("t4.c3", 32'(q_count), 3);
        push(1, 5'd9, 32'h909, 1, 5'd10, 32'hA0A);
        rf_stall = 1'b0;
        #1;
        chk("t4.mem_ready", 32'(mem_ready), 1);
        chk("t4.alu_ready", 32'(alu_ready), 0);
        tick();
        mem_valid = 1'b0;
        #1;
        wr("t4.w6", 1, 5'd6, 32'h606, 3'd3);
        chk("t4.alu_ready1", 32'(alu_ready), 1);
        tick();
        alu_valid = 1'b0;
        #1;
        wr("t4.w7", 1, 5'd7, 32'h707, 3'd3);
        tick();
        wr("t4.w8", 1, 5'd8, 32'h808, 3'd2);
        tick();
        wr("t4.w9", 1, 5'd9, 32'h909, 3'd1);
        tick();
        wr("t4.w10", 1, 5'd10, 32'hA0A, 3'd0);
        tick();
        chk("t4.idle", 32'(rf_write), 0);

        // rd == 0 is accepted and discarded
        push(0, 0, 0, 1, 5'd0, 32'hFFFFFFFF);
        fwd_rs1 = 5'd0;
        #1;
        chk("t5.alu_ready", 32'(alu_ready), 1);
        tick();
        push(0, 0, 0, 0, 0, 0);
        #1;
        wr("t5.acc", 0, 0, 0, 3'd0);
        chk("t5.hit", 32'(fwd_hit1), 0);
        tick();
        wr("t5.nowr", 0, 0, 0, 3'd0);

        // reset mid-operation
        rf_stall = 1'b1;
        push(1, 5'd11, 32'hB0B, 1, 5'd12, 32'hC0C);
        tick();
        push(1, 5'd13, 32'hD0D, 0, 0, 0);
        tick();
        push(0, 0, 0, 0, 0, 0);
        chk("t6.c3", 32'(q_count), 3);
        rf_stall = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("t6.rst.count", 32'(q_count), 0);
        chk("t6.rst.write", 32'(rf_write), 0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            wr("t6.after", 0, 0, 0, 3'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
